// File: rtl/axi_node_pkg.sv
// rtl/axi_node_pkg.sv - shared types for the AXI node read-address path
package axi_node_pkg;

   // Rule bounds are stored wide enough for any supported address width
   localparam int unsigned RULE_ADDR_W = 64;

   typedef enum logic [1:0] {
      AR_IDLE,
      AR_ISSUE,
      AR_ERROR
   } ar_disp_state_e;

   typedef struct packed {
      logic [RULE_ADDR_W-1:0] start_addr;
      logic [RULE_ADDR_W-1:0] end_addr;
      logic                   en;
   } addr_rule_t;

endpackage

// File: rtl/axi_AR_addr_decoder.sv
// rtl/axi_AR_addr_decoder.sv - maps an AR address onto a one-hot initiator port
module axi_AR_addr_decoder
   import axi_node_pkg::*;
#(
   parameter int unsigned AXI_ADDR_W  = 32,
   parameter int unsigned N_INIT_PORT = 2
) (
   input  logic [AXI_ADDR_W-1:0]  addr_i,
   input  addr_rule_t             rules_i [N_INIT_PORT],
   output logic [N_INIT_PORT-1:0] dest_o,
   output logic                   miss_o
);

   logic [RULE_ADDR_W-1:0] addr_ext;
   logic                   found;

   assign addr_ext = RULE_ADDR_W'(addr_i);

   // Inclusive range match; the lowest-indexed matching port wins
   always_comb begin
      dest_o = '0;
      found  = 1'b0;
      for (int i = 0; i < N_INIT_PORT; i++) begin
         if (!found && rules_i[i].en &&
             (rules_i[i].start_addr <= addr_ext) &&
             (addr_ext <= rules_i[i].end_addr)) begin
            dest_o[i] = 1'b1;
            found     = 1'b1;
         end
      end
      miss_o = ~found;
   end

endmodule

// File: rtl/axi_ar_dispatcher.sv
// rtl/axi_ar_dispatcher.sv - AR front end: decode, forward hits, raise error requests on misses
module axi_ar_dispatcher
   import axi_node_pkg::*;
#(
   parameter int unsigned AXI_ADDR_W  = 32,
   parameter int unsigned AXI_ID_IN   = 16,
   parameter int unsigned AXI_USER_W  = 6,
   parameter int unsigned N_INIT_PORT = 2,
   parameter int unsigned N_TARG_PORT = 7,
   parameter int unsigned TARG_IDX    = 0,
   parameter int unsigned LOG_N_TARG  = $clog2(N_TARG_PORT),
   parameter int unsigned AXI_ID_OUT  = AXI_ID_IN + LOG_N_TARG
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [AXI_ID_IN-1:0]                  arid_i,
   input  logic [AXI_ADDR_W-1:0]                 araddr_i,
   input  logic [7:0]                            arlen_i,
   input  logic [2:0]                            arsize_i,
   input  logic [1:0]                            arburst_i,
   input  logic                                  arlock_i,
   input  logic [3:0]                            arcache_i,
   input  logic [2:0]                            arprot_i,
   input  logic [3:0]                            arregion_i,
   input  logic [3:0]                            arqos_i,
   input  logic [AXI_USER_W-1:0]                 aruser_i,
   input  logic                                  arvalid_i,
   output logic                                  arready_o,
   output logic [AXI_ID_OUT-1:0]                 arid_o,
   output logic [AXI_ADDR_W-1:0]                 araddr_o,
   output logic [7:0]                            arlen_o,
   output logic [2:0]                            arsize_o,
   output logic [1:0]                            arburst_o,
   output logic                                  arlock_o,
   output logic [3:0]                            arcache_o,
   output logic [2:0]                            arprot_o,
   output logic [3:0]                            arregion_o,
   output logic [3:0]                            arqos_o,
   output logic [AXI_USER_W-1:0]                 aruser_o,
   output logic [N_INIT_PORT-1:0]                arvalid_o,
   input  logic [N_INIT_PORT-1:0]                arready_i,
   input  logic [N_INIT_PORT-1:0][AXI_ADDR_W-1:0] start_addr_i,
   input  logic [N_INIT_PORT-1:0][AXI_ADDR_W-1:0] end_addr_i,
   input  logic [N_INIT_PORT-1:0]                rule_en_i,
   output logic                                  incr_req_o,
   input  logic                                  full_counter_i,
   input  logic                                  outstanding_trans_i,
   output logic                                  error_req_o,
   input  logic                                  error_gnt_i,
   output logic [7:0]                            error_len_o,
   output logic [AXI_USER_W-1:0]                 error_user_o,
   output logic [AXI_ID_IN-1:0]                  error_id_o,
   output logic                                  sample_ardata_info_o
);

   ar_disp_state_e state_q, state_d;

   addr_rule_t             rules [N_INIT_PORT];
   logic [N_INIT_PORT-1:0] dec_dest;
   logic                   dec_miss;

   logic [N_INIT_PORT-1:0] dest_q;
   logic [N_INIT_PORT-1:0] last_dest_q, last_dest_d;
   logic                   held_q, held_d;
   logic                   sample_q, sample_d;
   logic                   accept;
   logic                   guard_ok;

   logic [AXI_ID_IN-1:0]   arid_q;
   logic [AXI_ADDR_W-1:0]  araddr_q;
   logic [7:0]             arlen_q;
   logic [2:0]             arsize_q;
   logic [1:0]             arburst_q;
   logic                   arlock_q;
   logic [3:0]             arcache_q;
   logic [2:0]             arprot_q;
   logic [3:0]             arregion_q;
   logic [3:0]             arqos_q;
   logic [AXI_USER_W-1:0]  aruser_q;

   // Pack the flat rule ports into the shared rule struct
   always_comb begin
      for (int i = 0; i < N_INIT_PORT; i++) begin
         rules[i].start_addr = RULE_ADDR_W'(start_addr_i[i]);
         rules[i].end_addr   = RULE_ADDR_W'(end_addr_i[i]);
         rules[i].en         = rule_en_i[i];
      end
   end

   axi_AR_addr_decoder #(
      .AXI_ADDR_W  (AXI_ADDR_W),
      .N_INIT_PORT (N_INIT_PORT)
   ) u_decoder (
      .addr_i  (araddr_i),
      .rules_i (rules),
      .dest_o  (dec_dest),
      .miss_o  (dec_miss)
   );

   // While reads are in flight, only the slave that already holds the stream may be targeted
   assign guard_ok = ~full_counter_i & (~outstanding_trans_i | (dest_q == last_dest_q));

   // Next-state and handshake outputs; arvalid_o stays up once raised regardless of the guard
   always_comb begin
      state_d     = state_q;
      arready_o   = 1'b0;
      arvalid_o   = '0;
      incr_req_o  = 1'b0;
      error_req_o = 1'b0;
      held_d      = 1'b0;
      last_dest_d = last_dest_q;
      sample_d    = 1'b0;
      accept      = 1'b0;
      case (state_q)
         AR_IDLE: begin
            arready_o = 1'b1;
            if (arvalid_i) begin
               accept = 1'b1;
               if (dec_miss) begin
                  state_d  = AR_ERROR;
                  sample_d = 1'b1;
               end else begin
                  state_d = AR_ISSUE;
               end
            end
         end
         AR_ISSUE: begin
            if (held_q || guard_ok) begin
               arvalid_o = dest_q;
            end
            if (|(arvalid_o & arready_i)) begin
               incr_req_o  = 1'b1;
               last_dest_d = dest_q;
               state_d     = AR_IDLE;
            end else begin
               held_d = |arvalid_o;
            end
         end
         AR_ERROR: begin
            error_req_o = 1'b1;
            if (error_gnt_i) begin
               state_d = AR_IDLE;
            end
         end
         default: state_d = AR_IDLE;
      endcase
   end

   // State, ordering history and one-shot flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= AR_IDLE;
         last_dest_q <= N_INIT_PORT'(1);
         held_q      <= 1'b0;
         sample_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_dest_q <= last_dest_d;
         held_q      <= held_d;
         sample_q    <= sample_d;
      end
   end

   // Capture the accepted request; held unchanged until the next accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dest_q     <= '0;
         arid_q     <= '0;
         araddr_q   <= '0;
         arlen_q    <= '0;
         arsize_q   <= '0;
         arburst_q  <= '0;
         arlock_q   <= 1'b0;
         arcache_q  <= '0;
         arprot_q   <= '0;
         arregion_q <= '0;
         arqos_q    <= '0;
         aruser_q   <= '0;
      end else if (accept) begin
         dest_q     <= dec_dest;
         arid_q     <= arid_i;
         araddr_q   <= araddr_i;
         arlen_q    <= arlen_i;
         arsize_q   <= arsize_i;
         arburst_q  <= arburst_i;
         arlock_q   <= arlock_i;
         arcache_q  <= arcache_i;
         arprot_q   <= arprot_i;
         arregion_q <= arregion_i;
         arqos_q    <= arqos_i;
         aruser_q   <= aruser_i;
      end
   end

   assign arid_o               = {LOG_N_TARG'(TARG_IDX), arid_q};
   assign araddr_o             = araddr_q;
   assign arlen_o              = arlen_q;
   assign arsize_o             = arsize_q;
   assign arburst_o            = arburst_q;
   assign arlock_o             = arlock_q;
   assign arcache_o            = arcache_q;
   assign arprot_o             = arprot_q;
   assign arregion_o           = arregion_q;
   assign arqos_o              = arqos_q;
   assign aruser_o             = aruser_q;
   assign error_len_o          = arlen_q;
   assign error_user_o         = aruser_q;
   assign error_id_o           = arid_q;
   assign sample_ardata_info_o = sample_q;

endmodule
